// File: rtl/math_adder_8bit_seq.sv
`default_nettype none
// ============================================================================
// Module   : math_adder_8bit_seq
// Brief    : Bit-serial adder; ripples one bit per clock, LSB first, and
//            reports {error, sum} = a + b + carryIn with a one-cycle done pulse.
// Revision : 1.0 - initial release
// ============================================================================
module math_adder_8bit_seq #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             carryIn,
    output logic [WIDTH-1:0] sum,
    output logic             error,
    output logic             busy,
    output logic             done
);

    localparam int c_cnt_w = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(WIDTH - 1);
    localparam logic [c_cnt_w-1:0] c_one  = c_cnt_w'(1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADD  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_next;

    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [WIDTH-1:0]   r_acc;
    logic               r_carry;
    logic [c_cnt_w-1:0] r_cnt;
    logic [WIDTH-1:0]   r_sum;
    logic               r_error;
    logic               r_done;

    logic               w_sum_bit;
    logic               w_carry_next;
    logic [WIDTH-1:0]   w_acc_next;
    logic               w_last;

    // Operands shift right each ADD cycle so bit 0 is always the current bit;
    // result bits enter the accumulator at the MSB and walk down to position.
    assign w_sum_bit    = r_a[0] ^ r_b[0] ^ r_carry;
    assign w_carry_next = (r_a[0] & r_b[0]) | (r_a[0] & r_carry) | (r_b[0] & r_carry);
    assign w_acc_next   = {w_sum_bit, r_acc[WIDTH-1:1]};
    assign w_last       = (r_cnt == c_last);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: if (start)  w_state_next = ST_ADD;
            ST_ADD:  if (w_last) w_state_next = ST_DONE;
            ST_DONE: w_state_next = ST_IDLE;
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_a     <= '0;
            r_b     <= '0;
            r_acc   <= '0;
            r_carry <= 1'b0;
            r_cnt   <= '0;
            r_sum   <= '0;
            r_error <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_a     <= a;
                        r_b     <= b;
                        r_carry <= carryIn;
                        r_acc   <= '0;
                        r_cnt   <= '0;
                    end
                end
                ST_ADD: begin
                    r_a     <= r_a >> 1;
                    r_b     <= r_b >> 1;
                    r_carry <= w_carry_next;
                    r_acc   <= w_acc_next;
                    r_cnt   <= r_cnt + c_one;
                    // Visible result only changes once the final bit is known.
                    if (w_last) begin
                        r_sum   <= w_acc_next;
                        r_error <= w_carry_next;
                        r_done  <= 1'b1;
                    end
                end
                ST_DONE: begin
                    r_done <= 1'b0;
                end
                default: begin
                    r_done <= 1'b0;
                end
            endcase
        end
    end

    assign sum   = r_sum;
    assign error = r_error;
    assign done  = r_done;
    assign busy  = (r_state != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_math_adder_8bit_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_math_adder_8bit_seq
// Brief    : Directed vector table plus multi-cycle corner sequences.
// Revision : 1.0 - initial release
// ============================================================================
module tb_math_adder_8bit_seq;

    localparam int WIDTH = 8;

    logic             clk = 1'b0;
    logic             reset;
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             carry_in;
    logic [WIDTH-1:0] sum;
    logic             error;
    logic             busy;
    logic             done;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic [7:0] va;
        logic [7:0] vb;
        logic       vc;
        logic [7:0] es;
        logic       ee;
    } vec_t;

    vec_t vecs[10];

    always #5 clk = ~clk;

    math_adder_8bit_seq #(.WIDTH(WIDTH)) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .a       (a),
        .b       (b),
        .carryIn (carry_in),
        .sum     (sum),
        .error   (error),
        .busy    (busy),
        .done    (done)
    );

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    // One full operation with start pulsed for a single cycle.
    task automatic run_op(input string nm, input logic [7:0] va, input logic [7:0] vb,
                          input logic vc, input logic [7:0] es, input logic ee);
        logic [7:0] held_s;
        logic       held_e;
        int         k;
        int         unstable;
        int         not_busy;
        @(negedge clk);
        a = va; b = vb; carry_in = vc; start = 1'b1;
        held_s = sum; held_e = error;
        @(negedge clk);
        start = 1'b0;
        a = ~va; b = ~vb; carry_in = ~vc;
        k = 0; unstable = 0; not_busy = 0;
        while (!done && k < 30) begin
            if (sum !== held_s || error !== held_e) unstable++;
            if (busy !== 1'b1) not_busy++;
            @(negedge clk);
            k++;
        end
        check({nm, "_latency"}, k, WIDTH);
        check({nm, "_hold"}, unstable, 0);
        check({nm, "_busy"}, not_busy, 0);
        check({nm, "_sum"}, sum, es);
        check({nm, "_err"}, error, ee);
        @(negedge clk);
        check({nm, "_pulse_end"}, {busy, done}, 2'b00);
    endtask

    initial begin
        int k;
        int n_done;
        int unstable;
        logic [7:0] exp_s;
        logic       exp_e;

        vecs[0] = '{8'h0F, 8'h05, 1'b0, 8'h14, 1'b0};
        vecs[1] = '{8'hAA, 8'h55, 1'b1, 8'h00, 1'b1};
        vecs[2] = '{8'hF0, 8'h0F, 1'b0, 8'hFF, 1'b0};
        vecs[3] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
        vecs[4] = '{8'h81, 8'h81, 1'b0, 8'h02, 1'b1};
        vecs[5] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0};
        vecs[6] = '{8'h00, 8'h00, 1'b1, 8'h01, 1'b0};
        vecs[7] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0};
        vecs[8] = '{8'hFF, 8'h00, 1'b1, 8'h00, 1'b1};
        vecs[9] = '{8'h12, 8'h34, 1'b0, 8'h46, 1'b0};

        reset = 1'b1; start = 1'b0; a = '0; b = '0; carry_in = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_outputs", {sum, error, busy, done}, 11'h000);
        reset = 1'b0;
        unstable = 0;
        repeat (5) begin
            @(negedge clk);
            if ({sum, error, busy, done} !== 11'h000) unstable++;
        end
        check("idle_no_change", unstable, 0);

        for (int i = 0; i < 10; i++) begin
            run_op($sformatf("vec%0d", i), vecs[i].va, vecs[i].vb, vecs[i].vc,
                   vecs[i].es, vecs[i].ee);
        end

        // start and operand change during ADD must be ignored
        @(negedge clk);
        a = 8'hFF; b = 8'hFF; carry_in = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        a = 8'h00; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        k = 4;
        while (!done && k < 30) begin
            @(negedge clk);
            k++;
        end
        check("ign_latency", k, WIDTH);
        check("ign_sum", sum, 8'hFF);
        check("ign_err", error, 1'b1);
        n_done = 0;
        repeat (15) begin
            if (done) n_done++;
            @(negedge clk);
        end
        check("ign_single_done", n_done, 1);

        // reset in the middle of ADD discards the operation
        a = 8'h81; b = 8'h81; carry_in = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("midrst_outputs", {sum, error, busy, done}, 11'h000);
        n_done = 0;
        repeat (12) begin
            @(negedge clk);
            if (done || busy) n_done++;
        end
        check("midrst_quiet", n_done, 0);
        run_op("restart", 8'h81, 8'h81, 1'b0, 8'h02, 1'b1);

        // start held high: back-to-back operations with alternating operands
        @(negedge clk);
        a = 8'h0F; b = 8'h05; carry_in = 1'b0; start = 1'b1;
        exp_s = sum; exp_e = error;
        for (int i = 0; i < 4; i++) begin
            k = 0; unstable = 0;
            do begin
                @(negedge clk);
                k++;
                if (!done && (sum !== exp_s || error !== exp_e)) unstable++;
            end while (!done && k < 30);
            check($sformatf("held%0d_interval", i), k, (i == 0) ? WIDTH + 1 : WIDTH + 2);
            check($sformatf("held%0d_hold", i), unstable, 0);
            exp_s = (i % 2 == 0) ? 8'h14 : 8'h2D;
            exp_e = (i % 2 == 0) ? 1'b0  : 1'b1;
            check($sformatf("held%0d_sum", i), sum, exp_s);
            check($sformatf("held%0d_err", i), error, exp_e);
            check($sformatf("held%0d_busy", i), busy, 1'b1);
            if (i % 2 == 0) begin
                a = 8'hC8; b = 8'h64; carry_in = 1'b1;
            end else begin
                a = 8'h0F; b = 8'h05; carry_in = 1'b0;
            end
            if (i == 3) start = 1'b0;
        end
        @(negedge clk);
        check("held_done_width", done, 1'b0);
        repeat (3) @(negedge clk);
        check("held_stop", {busy, done}, 2'b00);
        check("held_final_sum", sum, 8'h2D);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/math_adder_8bit_seq.md
Name: math_adder_8bit_seq

Overview:
Sequential bit-serial 8-bit adder. It is the addition counterpart of the calculator's subtractor datapath.
- Latches two operands and a carry-in on a start handshake.
- Ripples one bit per clock, LSB first.
- Reports the sum and an unsigned-overflow error with a one-cycle done pulse.
- Sits between the calculator FSM (operand/opcode control) and the result register/display path.

Parameters:
WIDTH, 8, operand and sum width in bits; bit counter sized to hold WIDTH-1.

Ports:
clk  input  1  system clock, rising-edge active
reset  input  1  synchronous, active-high reset
start  input  1  request; sampled only in IDLE
a  input  WIDTH  augend, captured when start is accepted
b  input  WIDTH  addend, captured when start is accepted
carryIn  input  1  carry into bit 0, captured when start is accepted
sum  output  WIDTH  registered result of last completed addition
error  output  1  carry out of MSB of last completed addition (unsigned overflow)
busy  output  1  high in ADD and DONE states
done  output  1  one-cycle pulse marking sum/error valid and updated

Behaviour:
- Reset (sampled at rising clk edge while reset=1):
  - State goes to IDLE.
  - sum=0, error=0, busy=0, done=0.
  - Internal operand, carry and bit-counter registers cleared.
  - Reset takes priority over all other inputs.
- States: IDLE, ADD, DONE.
- IDLE:
  - busy=0, done=0.
  - If start=1 at an edge: latch a, b, carryIn into internal shift/carry registers, clear the bit counter to 0, go to ADD.
  - If start=0: stay in IDLE.
- ADD:
  - busy=1. Each edge computes bit i = a_r[i] ^ b_r[i] ^ c and updates c = majority(a_r[i], b_r[i], c).
  - Result bit i goes into an internal accumulator; i increments.
  - On the edge that computes bit WIDTH-1: move the accumulator to sum, move the final carry to error, set done=1, go to DONE.
- DONE:
  - busy=1, done=1 for exactly this one cycle.
  - Next edge: done=0, busy=0, return to IDLE.
- Latency, with the start-accepting edge as edge 0:
  - Bits are computed on edges 1..WIDTH.
  - sum, error and done change at edge WIDTH; done=1 is first sampled at edge WIDTH+1.
  - For WIDTH=8: start-to-done is 9 edges.
  - Minimum issue interval is WIDTH+2 edges.
- start while busy=1 is ignored, with no queuing. start held high continuously re-triggers on the first IDLE cycle after DONE.
- Operand changes on a/b/carryIn after acceptance have no effect on the operation in flight.
- sum and error hold their value from completion until the next completion or reset. They never show partial results.
- Arithmetic is modulo 2^WIDTH:
  - {error, sum} = a + b + carryIn, with zero-extended operands.
  - error has unsigned meaning only; no signed-overflow flag.
- Reset mid-operation (ADD or DONE):
  - The in-flight result is discarded.
  - All outputs return to reset values on that edge; no done pulse is produced.

Test Plan:
- Reset for 2 cycles -> sum=0x00, error=0, busy=0, done=0; idle for 5 cycles with start=0 -> outputs unchanged.
- a=0x0F, b=0x05, carryIn=0, start pulsed 1 cycle -> busy high for 9 cycles; done pulse at edge 9 after acceptance; sum=0x14, error=0.
- a=0xAA, b=0x55, carryIn=1 -> sum=0x00, error=1. Then a=0xF0, b=0x0F, carryIn=0 -> sum=0xFF, error=0.
- a=0xFF, b=0xFF, carryIn=1 -> sum=0xFF, error=1. Change a=0x00 and pulse start at edge 3 of ADD -> ignored; result still 0xFF/1, single done pulse.
- Start a=0x81, b=0x81, carryIn=0; assert reset at edge 4 -> outputs zero, no done pulse. Restart the same operands -> sum=0x02, error=1.
- start held high with alternating operands -> back-to-back operations every 10 edges, each with a correct single-cycle done pulse and sum/error stable between pulses.
